logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares the single combinational logical unit (AND/OR/XOR/NOT) between NUM_REQ requesters, such as the execute stage, the debug port and the microcode sequencer.
- Arbitration is round-robin. Operands and opcode are held in registers while the unit evaluates, and the result is returned on a shared response bus tagged with the requester index.
- Sits between the requesters and the logical unit: it drives the unit's opcode and operand inputs and samples its output.

Parameters:
- WORD_SIZE, 19, datapath width in bits.
- OPCODE_W, 5, opcode field width; encodings come from the opcodes package.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must equal clog2(NUM_REQ).

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, NUM_REQ, per-requester request valid.
- req_ready, output, NUM_REQ, one-hot grant/accept.
- req_opcode, input, NUM_REQ*OPCODE_W, flattened opcodes; requester k occupies slice k.
- req_op1, input, NUM_REQ*WORD_SIZE, flattened operand 1.
- req_op2, input, NUM_REQ*WORD_SIZE, flattened operand 2.
- lu_opcode, output, OPCODE_W, opcode driven to the logical unit.
- lu_op1, output, WORD_SIZE, operand 1 to the logical unit.
- lu_op2, output, WORD_SIZE, operand 2 to the logical unit.
- lu_out, input, WORD_SIZE, logical unit result (combinational).
- resp_valid, output, 1, response valid.
- resp_ready, input, 1, response consumer ready.
- resp_id, output, ID_W, index of the requester owning the response.
- resp_data, output, WORD_SIZE, registered result.
- resp_err, output, 1, opcode was not AND/OR/XOR/NOT.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- Reset (rst=1 at a clock edge):
  - State = IDLE, rr_ptr = 0.
  - Holding registers, resp_data, resp_id, resp_err = 0.
  - resp_valid = 0, busy = 0, req_ready = 0, lu_* = 0.
  - Reset mid-transaction discards it; no response is ever issued for it.
- IDLE:
  - Grant g = first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready = onehot(g), combinational, in IDLE only; all zeros otherwise.
  - A handshake is req_valid[g] & req_ready[g]. On it, capture opcode/op1/op2 of slice g and g into the holding registers, then go to EXEC.
  - With no req_valid, stay in IDLE; rr_ptr is unchanged.
- EXEC (exactly 1 cycle):
  - lu_opcode/lu_op1/lu_op2 = holding registers.
  - At the edge: resp_data <= lu_out, resp_id <= g.
  - resp_err <= 1 if opcode is not in {AND, OR, XOR, NOT}; resp_data is then whatever lu_out gives (0 for undefined opcodes).
  - Go to RESP.
- lu_* outputs hold the last holding-register values in every state; they are zero only after reset.
- RESP:
  - resp_valid = 1; resp_data/resp_id/resp_err are stable until the handshake.
  - On resp_ready=1: go to IDLE, rr_ptr <= (g+1) mod NUM_REQ.
  - Otherwise hold indefinitely. New requests are not accepted; req_ready = 0.
- Latency and throughput:
  - Handshake at cycle N -> resp_valid first high at cycle N+2.
  - Minimum 3 cycles per transaction when resp_ready is tied high.
- Fairness:
  - Under continuous requests from all NUM_REQ requesters, each is granted exactly once per NUM_REQ transactions.
  - The pointer advances only on a completed response.
- A requester deasserting req_valid without a handshake is legal and is not recorded.
- req_* inputs are ignored outside IDLE; inputs must be stable only while valid in IDLE.
- NOT uses op1 only; op2 is captured but is don't-care.

Test Plan:
- Reset, then single request k=0, AND, op1=19'h7FFFF, op2=19'h00F0F -> req_ready=4'b0001 in the request cycle; 2 cycles later resp_valid=1, resp_id=0, resp_data=19'h00F0F, resp_err=0.
- All four requesters valid continuously, XOR with distinct operands, resp_ready=1 -> grant order 0,1,2,3,0; one response every 3 cycles; each resp_id matches the owner of its resp_data.
- Requester 2, NOT, op1=19'h00000, resp_ready held low 5 cycles -> resp_valid stays high with resp_data=19'h7FFFF stable; req_ready=0 throughout; release returns to IDLE.
- Requester 1 with an undefined opcode -> resp_err=1, resp_data=0; the next transaction has resp_err=0.
- rst asserted during EXEC with requester 3 active -> next cycle state IDLE, resp_valid=0, rr_ptr=0; no response for requester 3 ever appears.
- Requesters 1 and 3 valid, rr_ptr=2 -> 3 is granted first, then 1 (OR, 19'h40000 | 19'h00001 -> 19'h40001).

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one combinational logical unit among NUM_REQ requesters
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             per-requester request handshake (req_ready one-hot, IDLE only)
//   req_opcode/req_op1/req_op2      flattened per-requester opcode and operands (slice k = requester k)
//   lu_opcode/lu_op1/lu_op2/lu_out  drive and sample the external logical unit
//   resp_valid/resp_ready           response handshake
//   resp_id/resp_data/resp_err      owner index, registered result, unsupported-opcode flag
//   busy                            high outside IDLE
module logic_unit_arbiter #(
    parameter int WORD_SIZE = 19,
    parameter int OPCODE_W  = 5,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*OPCODE_W-1:0]   req_opcode,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  req_op1,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  req_op2,
    output logic [OPCODE_W-1:0]           lu_opcode,
    output logic [WORD_SIZE-1:0]          lu_op1,
    output logic [WORD_SIZE-1:0]          lu_op2,
    input  logic [WORD_SIZE-1:0]          lu_out,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [WORD_SIZE-1:0]          resp_data,
    output logic                          resp_err,
    output logic                          busy
);
    localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_OR  = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_NOT = OPCODE_W'(4);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0] rr_ptr, h_id, gnt;
    logic [OPCODE_W-1:0] h_opc;
    logic [WORD_SIZE-1:0] h_op1, h_op2;
    logic found;
    logic [ID_W-1:0] cand [NUM_REQ];
    // cand[k] is the k-th requester in search order starting at rr_ptr
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        assign cand[k] = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
    end
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (!found && req_valid[cand[i]]) begin
                found = 1'b1;
                gnt   = cand[i];
            end
    end
    always_comb begin
        state_nxt = state == IDLE ? (found ? EXEC : IDLE) :
                    state == EXEC ? RESP : (resp_ready ? IDLE : RESP);
    end
    assign req_ready  = (state == IDLE && found) ? NUM_REQ'(1) << gnt : '0;
    assign resp_valid = state == RESP;
    assign busy       = state != IDLE;
    assign lu_opcode  = h_opc;
    assign lu_op1     = h_op1;
    assign lu_op2     = h_op2;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            h_id      <= '0;
            h_opc     <= '0;
            h_op1     <= '0;
            h_op2     <= '0;
            resp_id   <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                h_id  <= gnt;
                h_opc <= req_opcode[int'(gnt)*OPCODE_W +: OPCODE_W];
                h_op1 <= req_op1[int'(gnt)*WORD_SIZE +: WORD_SIZE];
                h_op2 <= req_op2[int'(gnt)*WORD_SIZE +: WORD_SIZE];
            end
            if (state == EXEC) begin
                resp_data <= lu_out;
                resp_id   <= h_id;
                resp_err  <= !(h_opc inside {OP_AND, OP_OR, OP_XOR, OP_NOT});
            end
            // pointer moves past the owner only once its response is consumed
            if (state == RESP && resp_ready)
                rr_ptr <= ID_W'((int'(h_id) + 1) % NUM_REQ);
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: scoreboard bench for logic_unit_arbiter with a behavioural logical unit
module tb_logic_unit_arbiter;
    localparam logic [4:0] OP_AND = 5'h01, OP_OR = 5'h02, OP_XOR = 5'h03, OP_NOT = 5'h04, OP_BAD = 5'h1F;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [19:0] req_opcode = '0;
    logic [75:0] req_op1 = '0;
    logic [75:0] req_op2 = '0;
    logic [4:0]  lu_opcode;
    logic [18:0] lu_op1, lu_op2, lu_out;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [1:0]  resp_id;
    logic [18:0] resp_data;
    logic        resp_err;
    logic        busy;
    int checks = 0;
    int errors = 0;
    typedef struct packed {logic [1:0] id; logic [18:0] data; logic err;} exp_t;
    exp_t sb[$];

    logic_unit_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
        .lu_opcode(lu_opcode), .lu_op1(lu_op1), .lu_op2(lu_op2), .lu_out(lu_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        lu_out = '0;
        case (lu_opcode)
            OP_AND:  lu_out = lu_op1 & lu_op2;
            OP_OR:   lu_out = lu_op1 | lu_op2;
            OP_XOR:  lu_out = lu_op1 ^ lu_op2;
            OP_NOT:  lu_out = ~lu_op1;
            default: lu_out = '0;
        endcase
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // response is taken at the next rising edge; sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp_id", 32'(resp_id), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_data", 32'(resp_data), 32'(e.data));
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int k, logic [4:0] opc, logic [18:0] a, logic [18:0] b);
        req_opcode[k*5 +: 5]  = opc;
        req_op1[k*19 +: 19]   = a;
        req_op2[k*19 +: 19]   = b;
    endtask

    task automatic wait_idle;
        for (int n = 0; n < 10 && busy; n++) tick;
        chk("return_idle", 32'(busy), 0);
    endtask

    task automatic issue(int k, logic [4:0] opc, logic [18:0] a, logic [18:0] b, logic [18:0] ed, logic ee);
        set_req(k, opc, a, b);
        resp_ready = 1'b1;
        req_valid  = 4'(1 << k);
        #1 chk("grant", 32'(req_ready), 32'(1 << k));
        sb.push_back('{2'(k), ed, ee});
        tick;
        req_valid = '0;
        wait_idle;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset;
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_lu_op1", 32'(lu_op1), 0);
        chk("rst_resp_data", 32'(resp_data), 0);

        // single AND from requester 0, latency check
        set_req(0, OP_AND, 19'h7FFFF, 19'h00F0F);
        req_valid = 4'b0001;
        #1 chk("t1_req_ready", 32'(req_ready), 32'b0001);
        sb.push_back('{2'd0, 19'h00F0F, 1'b0});
        tick;
        req_valid = '0;
        chk("t1_exec_valid", 32'(resp_valid), 0);
        chk("t1_exec_busy", 32'(busy), 1);
        chk("t1_lu_op2", 32'(lu_op2), 32'h00F0F);
        tick;
        chk("t1_resp_valid", 32'(resp_valid), 1);
        tick;
        chk("t1_idle", 32'(busy), 0);

        // all requesters continuously valid, XOR
        do_reset;
        set_req(0, OP_XOR, 19'h0000F, 19'h0FFFF);
        set_req(1, OP_XOR, 19'h000F0, 19'h0FFFF);
        set_req(2, OP_XOR, 19'h00F00, 19'h0FFFF);
        set_req(3, OP_XOR, 19'h0F000, 19'h0FFFF);
        sb.push_back('{2'd0, 19'h0FFF0, 1'b0});
        sb.push_back('{2'd1, 19'h0FF0F, 1'b0});
        sb.push_back('{2'd2, 19'h0F0FF, 1'b0});
        sb.push_back('{2'd3, 19'h00FFF, 1'b0});
        sb.push_back('{2'd0, 19'h0FFF0, 1'b0});
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        for (int i = 1; i <= 15; i++) begin
            tick;
            if (i == 13) req_valid = '0;
            chk("t2_resp_cadence", 32'(resp_valid), 32'(i % 3 == 2));
        end

        // NOT with back-pressure
        set_req(2, OP_NOT, 19'h00000, 19'h12345);
        resp_ready = 1'b0;
        req_valid  = 4'b0100;
        #1 chk("t3_req_ready", 32'(req_ready), 32'b0100);
        sb.push_back('{2'd2, 19'h7FFFF, 1'b0});
        tick;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(resp_valid), 1);
            chk("t3_hold_data", 32'(resp_data), 32'h7FFFF);
            chk("t3_hold_ready", 32'(req_ready), 0);
            tick;
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        wait_idle;

        // undefined opcode, then a clean transaction
        issue(1, OP_BAD, 19'h7FFFF, 19'h7FFFF, 19'h00000, 1'b1);
        issue(0, OP_OR, 19'h0000F, 19'h000F0, 19'h000FF, 1'b0);

        // reset during EXEC discards requester 3
        set_req(3, OP_AND, 19'h7FFFF, 19'h7FFFF);
        req_valid = 4'b1000;
        tick;
        req_valid = '0;
        chk("t5_in_exec", 32'(busy), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t5_reset_valid", 32'(resp_valid), 0);
        chk("t5_reset_busy", 32'(busy), 0);
        req_valid = 4'b1111;
        #1 chk("t5_rr_ptr_zero", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick;

        // move pointer to 2, then 3 wins over 1
        issue(1, OP_AND, 19'h7FFFF, 19'h12345, 19'h12345, 1'b0);
        set_req(3, OP_OR, 19'h00F00, 19'h000F0);
        set_req(1, OP_OR, 19'h40000, 19'h00001);
        req_valid = 4'b1010;
        #1 chk("t6_first_grant", 32'(req_ready), 32'b1000);
        sb.push_back('{2'd3, 19'h00FF0, 1'b0});
        sb.push_back('{2'd1, 19'h40001, 1'b0});
        tick;
        tick;
        tick;
        chk("t6_second_grant", 32'(req_ready), 32'b0010);
        tick;
        req_valid = '0;
        wait_idle;

        tick;
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
